// File: rtl/super_pkg.sv
// Shared fetch-path definitions: legal fetch-word sizes, word width and
// address alignment helpers used by the prefetch engine and its address queue.
package super_pkg;

    localparam int unsigned ADDR_W              = 32;
    localparam int unsigned FETCH_BYTES_DEFAULT = 8;

    // Only 4-, 8- and 16-byte fetch words exist on the instruction bus.
    function automatic bit fetch_bytes_legal(input int unsigned fb);
        return (fb == 32'd4) || (fb == 32'd8) || (fb == 32'd16);
    endfunction

    // Width in bits of one fetch word.
    function automatic int unsigned fetch_word_w(input int unsigned fb);
        return 32'd8 * fb;
    endfunction

    // Clear the byte-offset bits so the address points at a fetch-word start.
    function automatic logic [ADDR_W-1:0] align_fetch(input logic [ADDR_W-1:0] addr,
                                                      input int unsigned       fb);
        return addr & ~(ADDR_W'(fb) - 32'd1);
    endfunction

endpackage

// File: rtl/pf_addr_queue.sv
// In-order FIFO of request addresses: one entry per granted request, popped
// when its response returns. The head is the address of the oldest request.
module pf_addr_queue
    import super_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic              pop_i,
    output logic [ADDR_W-1:0] head_addr_o
);

    localparam int unsigned     PtrW      = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned     LvlW      = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LAST_PTR  = PtrW'(Depth - 1);
    localparam logic [LvlW-1:0] DEPTH_LVL = LvlW'(Depth);

    logic [ADDR_W-1:0] mem_r [Depth];
    logic [PtrW-1:0]   wr_ptr_r;
    logic [PtrW-1:0]   rd_ptr_r;
    logic [LvlW-1:0]   level_r;
    logic              do_push_s;
    logic              do_pop_s;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LAST_PTR) ? {PtrW{1'b0}} : p + PtrW'(1'b1);
    endfunction

    // Guard against pop-when-empty and push-when-full.
    always_comb begin
        do_pop_s    = pop_i & (level_r != {LvlW{1'b0}});
        do_push_s   = push_i & ((level_r != DEPTH_LVL) | do_pop_s);
        head_addr_o = mem_r[rd_ptr_r];
    end

    // Storage, pointers and fill level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_r[i] <= {ADDR_W{1'b0}};
            end
            wr_ptr_r <= {PtrW{1'b0}};
            rd_ptr_r <= {PtrW{1'b0}};
            level_r  <= {LvlW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_addr_i;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + LvlW'(1'b1);
                2'b01:   level_r <= level_r - LvlW'(1'b1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/prefetch_buffer_nreq.sv
// Instruction prefetch engine: issues fetch-word requests, tracks up to
// NumReqs outstanding transactions, drops responses made stale by a branch
// and pushes surviving responses, tagged with their address, into the
// downstream fetch FIFO under credit control.
module prefetch_buffer_nreq
    import super_pkg::*;
#(
    parameter int unsigned NumReqs    = 2,
    parameter int unsigned FetchBytes = FETCH_BYTES_DEFAULT,
    parameter bit          StopOnErr  = 1'b1,
    parameter int unsigned CntW       = $clog2(NumReqs + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    input  logic                    branch_i,
    input  logic [31:0]             addr_i,
    input  logic [CntW-1:0]         fifo_free_i,
    output logic                    fifo_push_o,
    output logic [8*FetchBytes-1:0] fifo_rdata_o,
    output logic [31:0]             fifo_addr_o,
    output logic                    fifo_err_o,
    output logic                    instr_req_o,
    input  logic                    instr_gnt_i,
    output logic [31:0]             instr_addr_o,
    input  logic [8*FetchBytes-1:0] instr_rdata_i,
    input  logic                    instr_err_i,
    input  logic                    instr_rvalid_i,
    output logic                    busy_o,
    output logic                    err_halt_o
);

    localparam logic [CntW-1:0] MAX_OUT  = CntW'(NumReqs);
    localparam logic [31:0]     WORD_INC = 32'(FetchBytes);

    logic [CntW-1:0] out_cnt_r;
    logic [CntW-1:0] disc_cnt_r;
    logic            held_r;
    logic            held_disc_r;
    logic            err_halt_r;
    logic [31:0]     held_addr_r;
    logic [31:0]     fetch_addr_r;

    logic            live_s;
    logic            new_s;
    logic            req_s;
    logic            gnt_taken_s;
    logic            push_s;
    logic [31:0]     branch_addr_s;
    logic [31:0]     req_addr_s;
    logic [31:0]     head_addr_s;
    logic [CntW-1:0] out_cnt_nxt_s;
    logic [CntW-1:0] disc_cnt_nxt_s;

    // Request decision, address select and response bypass; everything is
    // forced low while reset is asserted.
    always_comb begin
        live_s        = ~rst_i;
        branch_addr_s = align_fetch(addr_i, FetchBytes);
        new_s         = live_s & req_i & ~err_halt_r & ~held_r & (out_cnt_r < MAX_OUT)
                        & ((out_cnt_r < fifo_free_i) | branch_i);
        req_s         = live_s & (held_r | new_s);
        if (held_r) begin
            req_addr_s = held_addr_r;
        end else if (branch_i) begin
            req_addr_s = branch_addr_s;
        end else begin
            req_addr_s = fetch_addr_r;
        end
        gnt_taken_s   = req_s & instr_gnt_i;
        push_s        = live_s & instr_rvalid_i & (disc_cnt_r == {CntW{1'b0}});

        instr_req_o   = req_s;
        instr_addr_o  = live_s ? req_addr_s : 32'h0;
        fifo_push_o   = push_s;
        fifo_rdata_o  = live_s ? instr_rdata_i : {(8*FetchBytes){1'b0}};
        fifo_err_o    = live_s & instr_err_i;
        fifo_addr_o   = live_s ? head_addr_s : 32'h0;
        busy_o        = req_s | (out_cnt_r != {CntW{1'b0}});
        err_halt_o    = err_halt_r;
    end

    // Outstanding and discard counters; a branch snapshots everything still
    // in flight after this cycle's response, plus a held request granted now.
    always_comb begin
        out_cnt_nxt_s = out_cnt_r + CntW'(gnt_taken_s) - CntW'(instr_rvalid_i);
        if (branch_i) begin
            disc_cnt_nxt_s = out_cnt_r - CntW'(instr_rvalid_i) + CntW'(gnt_taken_s & held_r);
        end else begin
            disc_cnt_nxt_s = disc_cnt_r
                             - CntW'(instr_rvalid_i & (disc_cnt_r != {CntW{1'b0}}))
                             + CntW'(gnt_taken_s & held_r & held_disc_r);
        end
    end

    // Engine state: counters, held request, fetch pointer and error stop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_cnt_r    <= {CntW{1'b0}};
            disc_cnt_r   <= {CntW{1'b0}};
            held_r       <= 1'b0;
            held_disc_r  <= 1'b0;
            held_addr_r  <= 32'h0;
            fetch_addr_r <= 32'h0;
            err_halt_r   <= 1'b0;
        end else begin
            out_cnt_r  <= out_cnt_nxt_s;
            disc_cnt_r <= disc_cnt_nxt_s;

            if (gnt_taken_s) begin
                held_r      <= 1'b0;
                held_disc_r <= 1'b0;
            end else if (req_s) begin
                held_r      <= 1'b1;
                held_addr_r <= req_addr_s;
                held_disc_r <= held_disc_r | (held_r & branch_i);
            end else begin
                held_r      <= held_r;
                held_disc_r <= held_disc_r;
            end

            if (branch_i) begin
                fetch_addr_r <= branch_addr_s + (new_s ? WORD_INC : 32'h0);
            end else if (new_s) begin
                fetch_addr_r <= fetch_addr_r + WORD_INC;
            end else begin
                fetch_addr_r <= fetch_addr_r;
            end

            if (branch_i) begin
                err_halt_r <= 1'b0;
            end else if (StopOnErr && push_s && instr_err_i) begin
                err_halt_r <= 1'b1;
            end else begin
                err_halt_r <= err_halt_r;
            end
        end
    end

    pf_addr_queue #(
        .Depth       (NumReqs)
    ) u_addr_queue (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (gnt_taken_s),
        .push_addr_i (req_addr_s),
        .pop_i       (live_s & instr_rvalid_i),
        .head_addr_o (head_addr_s)
    );

endmodule
